// File: rtl/muldiv_if.sv
// Signal bundle between the EXE/ID pipeline control and the multiply/divide sequencer.
// The pipeline side is the master; muldiv_ctrl is the slave.
interface muldiv_if;
  logic        EXE_Valid;
  logic [2:0]  EXE_MDOp;
  logic        EXE_Flush;
  logic        Pipe_Stall;
  logic        ID_ReadHILO;
  logic        Div_Done;
  logic        Mul_Start;
  logic        Div_Start;
  logic        MD_Signed;
  logic        Div_Cancel;
  logic        HILO_Wen;
  logic [1:0]  HILO_WSel;
  logic        EXE_MD_Stall;
  logic        ID_HILO_Stall;
  logic        MD_Busy;
  logic [31:0] MD_StallCnt;

  modport master (
    output EXE_Valid, EXE_MDOp, EXE_Flush, Pipe_Stall, ID_ReadHILO, Div_Done,
    input  Mul_Start, Div_Start, MD_Signed, Div_Cancel, HILO_Wen, HILO_WSel,
           EXE_MD_Stall, ID_HILO_Stall, MD_Busy, MD_StallCnt
  );

  modport slave (
    input  EXE_Valid, EXE_MDOp, EXE_Flush, Pipe_Stall, ID_ReadHILO, Div_Done,
    output Mul_Start, Div_Start, MD_Signed, Div_Cancel, HILO_Wen, HILO_WSel,
           EXE_MD_Stall, ID_HILO_Stall, MD_Busy, MD_StallCnt
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier/divider and the HI/LO register pair beside EXE.
// Starts operations, holds EXE while they run, commits HI/LO once and cancels on flush.
module muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] stall_cnt_r;

  logic        go_s, is_mul_s, is_div_s, is_mt_s, signed_op_s;
  logic        mul_start_s, div_start_s, div_cancel_s, wen_s;
  logic        exe_stall_s, id_stall_s, busy_s;
  logic [1:0]  wsel_s;

  // Opcode decode; code 0 and 7 decode as no operation.
  always_comb begin
    go_s        = md.EXE_Valid & ~md.EXE_Flush;
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_mt_s     = 1'b0;
    signed_op_s = 1'b0;
    case (md.EXE_MDOp)
      3'd1:    begin is_mul_s = 1'b1; signed_op_s = 1'b1; end
      3'd2:    is_mul_s = 1'b1;
      3'd3:    begin is_div_s = 1'b1; signed_op_s = 1'b1; end
      3'd4:    is_div_s = 1'b1;
      3'd5,
      3'd6:    is_mt_s = 1'b1;
      default: is_mul_s = 1'b0;
    endcase
  end

  // Next-state and output decode; everything stays quiet while rst is high.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    mul_start_s  = 1'b0;
    div_start_s  = 1'b0;
    div_cancel_s = 1'b0;
    wen_s        = 1'b0;
    wsel_s       = 2'b00;
    exe_stall_s  = 1'b0;
    id_stall_s   = 1'b0;
    busy_s       = 1'b0;
    if (!rst) begin
      case (state_r)
        ST_IDLE: begin
          id_stall_s = md.ID_ReadHILO & go_s & (is_mul_s | is_div_s | is_mt_s);
          if (go_s & is_mul_s) begin
            mul_start_s = 1'b1;
            exe_stall_s = 1'b1;
            cnt_s       = MUL_LOAD;
            state_s     = ST_MUL;
          end else if (go_s & is_div_s) begin
            div_start_s = 1'b1;
            exe_stall_s = 1'b1;
            state_s     = ST_DIV;
          end else if (go_s & is_mt_s) begin
            // MTHI/MTLO write on every valid cycle; a repeat under Pipe_Stall rewrites the same value.
            wen_s  = 1'b1;
            wsel_s = (md.EXE_MDOp == 3'd5) ? 2'b10 : 2'b01;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          busy_s      = 1'b1;
          exe_stall_s = 1'b1;
          id_stall_s  = md.ID_ReadHILO;
          if (md.EXE_Flush) begin
            state_s = ST_IDLE;
          end else if (cnt_r == 4'd0) begin
            state_s = ST_DONE;
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end
        ST_DIV: begin
          busy_s      = 1'b1;
          exe_stall_s = 1'b1;
          id_stall_s  = md.ID_ReadHILO;
          if (md.EXE_Flush) begin
            div_cancel_s = 1'b1;
            state_s      = ST_IDLE;
          end else if (md.Div_Done) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DIV;
          end
        end
        ST_DONE: begin
          busy_s     = 1'b1;
          id_stall_s = md.ID_ReadHILO;
          if (md.EXE_Flush) begin
            state_s = ST_IDLE;
          end else begin
            wen_s   = 1'b1;
            wsel_s  = 2'b11;
            state_s = md.Pipe_Stall ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Result already committed; wait for EXE to move on so the same op is not restarted.
          if (!md.Pipe_Stall || md.EXE_Flush) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = ST_IDLE;
    end
  end

  // State and multiply latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Saturating count of EXE stall cycles caused by multiply/divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (exe_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign md.Mul_Start     = mul_start_s;
  assign md.Div_Start     = div_start_s;
  assign md.MD_Signed     = (mul_start_s | div_start_s) & signed_op_s;
  assign md.Div_Cancel    = div_cancel_s;
  assign md.HILO_Wen      = wen_s;
  assign md.HILO_WSel     = wsel_s;
  assign md.EXE_MD_Stall  = exe_stall_s;
  assign md.ID_HILO_Stall = id_stall_s;
  assign md.MD_Busy       = busy_s;
  assign md.MD_StallCnt   = rst ? 32'd0 : stall_cnt_r;

endmodule
